// File: rtl/bus_mem.sv
// bus_mem -- asynchronous-handshake bus memory slave.
//
// A strobe from an initiator in another clock domain is synchronised, its
// rising edge starts a transaction, and the slave answers with a registered
// memory-function-complete after a fixed number of wait cycles. During a read
// the slave drives the shared data bus. At all other times the data bus is
// left floating.
//
// Ports:
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset (memory contents are kept)
//   bus_strb  initiator strobe, asynchronous to clk
//   bus_rw    1 = read, 0 = write
//   bus_addr  byte address; word index is bus_addr[DEPTH_LOG2+1:2]
//   bus_mfc   memory-function-complete, high while in ACK
//   bus_data  bidirectional data; driven only during a read
//
// Optional feature: define BUS_MEM_RANGE_CHECK_EN to reject addresses at or
// above 4*2**DEPTH_LOG2. A rejected access completes the handshake, but it
// does not touch the array and it does not drive bus_data. Without the macro,
// addresses alias modulo the array size.
module bus_mem #(
  parameter int ADDR_SIZE   = 32,
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_strb,
  input  logic                 bus_rw,
  input  logic [ADDR_SIZE-1:0] bus_addr,
  output logic                 bus_mfc,
  inout  wire  [WORD_SIZE-1:0] bus_data
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, DRIVE, ACK, REL} state_t;

  state_t                state;
  logic                  sync1, strb_s, strb_p;
  logic [1:0]            flush;
  logic [CW-1:0]         cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  rw_q;
  logic [WORD_SIZE-1:0]  wdata_q, rdata_q;
  logic                  drive;
  logic                  acc_ok;
  logic                  start;
  logic                  addr_unused;

  logic [WORD_SIZE-1:0] mem [2**DEPTH_LOG2];

  assign start       = strb_s && !strb_p;
  assign bus_data    = drive ? rdata_q : 'z;
  assign addr_unused = ^bus_addr;

`ifdef BUS_MEM_RANGE_CHECK_EN
  logic in_range_q;
  logic addr_in_range;
  assign addr_in_range = (bus_addr >> (DEPTH_LOG2 + 2)) == '0;
  assign acc_ok        = in_range_q;

  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && start && !addr_in_range)
      $display("bus_mem: out-of-range access ignored, addr=%h", bus_addr);
  end
`else
  assign acc_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      strb_s  <= 1'b0;
      strb_p  <= 1'b1;
      flush   <= '0;
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      drive   <= 1'b0;
      bus_mfc <= 1'b0;
`ifdef BUS_MEM_RANGE_CHECK_EN
      in_range_q <= 1'b0;
`endif
    end else begin
      sync1  <= bus_strb;
      strb_s <= sync1;
      flush  <= {flush[0], 1'b1};
      // The synchroniser holds its reset zeros for two edges after release.
      // strb_p stays high until those zeros have drained, so that a strobe
      // held high across reset does not look like a fresh rising edge.
      if (flush[1])
        strb_p <= strb_s;

      case (state)
        IDLE: if (start) begin
          state   <= WAIT;
          cnt     <= CW'(WAIT_CYCLES - 1);
          idx_q   <= bus_addr[DEPTH_LOG2+1:2];
          rw_q    <= bus_rw;
          wdata_q <= bus_data;
`ifdef BUS_MEM_RANGE_CHECK_EN
          in_range_q <= addr_in_range;
`endif
        end
        WAIT: if (cnt == '0) begin
          state <= DRIVE;
          drive <= rw_q && acc_ok;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DRIVE: begin
          state   <= ACK;
          bus_mfc <= 1'b1;
        end
        ACK: if (!strb_s) begin
          state   <= REL;
          bus_mfc <= 1'b0;
          drive   <= 1'b0;
        end
        REL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The array has no reset. During reset the state is IDLE, so an
  // interrupted write never reaches the commit below.
  always_ff @(posedge clk) begin
    if (state == WAIT && cnt == '0 && rw_q)
      rdata_q <= mem[idx_q];
    if (state == DRIVE && !rw_q && acc_ok)
      mem[idx_q] <= wdata_q;
  end

endmodule
